// File: rtl/lif_pkg.sv
// Shared encodings and default sizing for the spike rate decoder.
package lif_pkg;

  localparam int NCH_DEF = 8;
  localparam int CW_DEF  = 8;

  // Counting FSM
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} cnt_st_e;

  // Result drain FSM
  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} drn_st_e;

endpackage

// File: rtl/spike_counter.sv
// One saturating per-channel spike counter with synchronous clear and enable.
// nxt_o exposes the value the counter would take this cycle (ignoring clear)
// so a window snapshot can include spikes of the window's final cycle.
module spike_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] nxt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Increment by the spike bit, holding at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Clear takes priority over counting
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike rate decoder: counts spikes per channel over a programmable
// window, snapshots the counts at window end and drains them one word per
// channel over a valid/ready port. A snapshot that arrives while the buffer
// still holds undelivered words is dropped and flagged as overrun.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] spike_in,
  input  logic [7:0]     win_len,
  input  logic           start,
  input  logic           stop,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2:0]     out_chan,
  output logic [CW-1:0]  out_count,
  output logic           overrun,
  output logic           busy
);

  cnt_st_e               cst_q;
  drn_st_e               dst_q;
  logic [8:0]            len_q;
  logic [8:0]            wcnt_q;
  logic [2:0]            chan_q;
  logic [NCH-1:0][CW-1:0] buf_q;
  logic                  ovr_q;

  logic [NCH-1:0][CW-1:0] cnt_cur, cnt_nxt;
  logic                  go, last, win_end, clr_cnt, cnt_en;

  // Window bookkeeping: stop beats both start and a coinciding window end
  always_comb begin
    go      = (cst_q == IDLE) && start && !stop;
    last    = (cst_q == COUNT) && (wcnt_q == (len_q - 9'd1));
    win_end = last && !stop;
    clr_cnt = go || win_end || ((cst_q == COUNT) && stop);
    cnt_en  = (cst_q == COUNT);
  end

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    spike_counter #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr_cnt),
      .en_i  (cnt_en),
      .inc_i (spike_in[g]),
      .cnt_o (cnt_cur[g]),
      .nxt_o (cnt_nxt[g])
    );
  end

  // Counting FSM; a zero length is stored as 256 via the 9th bit
  always_ff @(posedge clk) begin
    if (rst) begin
      cst_q  <= IDLE;
      len_q  <= '0;
      wcnt_q <= '0;
    end else begin
      case (cst_q)
        IDLE: if (go) begin
          len_q  <= {(win_len == 8'd0), win_len};
          wcnt_q <= '0;
          cst_q  <= COUNT;
        end
        COUNT: begin
          if (stop) begin
            cst_q  <= IDLE;
            wcnt_q <= '0;
          end else if (last) begin
            wcnt_q <= '0;
          end else begin
            wcnt_q <= wcnt_q + 9'd1;
          end
        end
        default: cst_q <= IDLE;
      endcase
    end
  end

  // Drain FSM; a snapshot is only accepted into an empty buffer, so one
  // landing on the final-word transfer cycle is still counted as overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q  <= EMPTY;
      chan_q <= '0;
      buf_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (go) ovr_q <= 1'b0;
      case (dst_q)
        EMPTY: if (win_end) begin
          buf_q  <= cnt_nxt;
          chan_q <= '0;
          dst_q  <= SEND;
        end
        SEND: begin
          if (win_end) ovr_q <= 1'b1;
          if (out_ready) begin
            if (chan_q == 3'(NCH-1)) begin
              chan_q <= '0;
              dst_q  <= EMPTY;
            end else begin
              chan_q <= chan_q + 3'd1;
            end
          end
        end
        default: dst_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = (dst_q == SEND);
  assign out_chan  = chan_q;
  assign out_count = (dst_q == SEND) ? buf_q[chan_q] : '0;
  assign overrun   = ovr_q;
  assign busy      = (cst_q == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: transaction-level reference model checked
// every cycle, directed scenarios plus a randomized soak.
module tb_spike_rate_decoder;

  localparam int NCH = 8;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] spike_in;
  logic [7:0]     win_len;
  logic           start, stop;
  logic           out_valid, out_ready;
  logic [2:0]     out_chan;
  logic [CW-1:0]  out_count;
  logic           overrun, busy;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .win_len(win_len),
    .start(start), .stop(stop), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_count(out_count), .overrun(overrun), .busy(busy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a window is "running" for L cycles, sums are plain
  // integers clamped at snapshot time; rem = undelivered words in buffer.
  bit run;
  int L, wc, rem, ovr;
  int sums[NCH];
  int wb[NCH];

  int lch[$];
  int lcnt[$];

  task automatic model_step();
    bit xfer, snap;
    if (rst) begin
      run = 0; L = 0; wc = 0; rem = 0; ovr = 0;
      foreach (sums[i]) begin sums[i] = 0; wb[i] = 0; end
      return;
    end
    xfer = (rem > 0) && out_ready;
    snap = 0;
    if (run) begin
      if (stop) run = 0;
      else begin
        foreach (sums[i]) sums[i] += spike_in[i];
        wc++;
        if (wc == L) begin
          snap = 1;
          if (rem == 0)
            foreach (wb[i]) wb[i] = (sums[i] > SAT) ? SAT : sums[i];
          foreach (sums[i]) sums[i] = 0;
          wc = 0;
        end
      end
    end else if (start && !stop) begin
      run = 1; L = (win_len == 0) ? 256 : win_len; wc = 0; ovr = 0;
      foreach (sums[i]) sums[i] = 0;
    end
    if (snap) begin
      if (rem == 0) rem = NCH;
      else          ovr = 1;
    end
    if (xfer) rem--;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("valid", out_valid, (rem > 0) ? 1 : 0);
    chk("chan",  out_chan,  (rem > 0) ? NCH - rem : 0);
    chk("count", out_count, (rem > 0) ? wb[NCH - rem] : 0);
    chk("ovr",   overrun,   ovr);
    chk("busy",  busy,      run ? 1 : 0);
    if (out_valid && out_ready) begin
      lch.push_back(out_chan);
      lcnt.push_back(out_count);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start(input int len);
    win_len = 8'(len); start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    int hold_cnt, hold_ch;
    bit found;

    rst = 1'b1; spike_in = '0; win_len = '0; start = 0; stop = 0; out_ready = 1'b1;
    ticks(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy",  busy, 0);
    rst = 1'b0;
    ticks(2);

    // Test 1: four full-spike cycles, 8 words of 4
    lch.delete(); lcnt.delete();
    pulse_start(4);
    spike_in = 8'hFF; ticks(4);
    spike_in = 8'h00; ticks(10);
    pulse_stop(); ticks(2);
    chk("t1_words", lch.size(), 8);
    for (int i = 0; i < 8 && i < lch.size(); i++) begin
      chk("t1_chan", lch[i], i);
      chk("t1_cnt",  lcnt[i], 4);
    end

    // Test 2: 256-cycle window saturates chan0
    lch.delete(); lcnt.delete();
    pulse_start(0);
    spike_in = 8'h01; ticks(256);
    spike_in = 8'h00;
    pulse_stop(); ticks(10);
    chk("t2_words", lch.size(), 8);
    if (lch.size() == 8) begin
      chk("t2_c0", lcnt[0], 255);
      for (int i = 1; i < 8; i++) chk("t2_cx", lcnt[i], 0);
    end

    // Test 3: consumer stalls, later windows overrun, first window delivered
    lch.delete(); lcnt.delete();
    out_ready = 1'b0;
    pulse_start(3);
    for (int i = 0; i < 20; i++) begin
      spike_in = NCH'($urandom);
      tick();
      if (i == 6) begin hold_cnt = out_count; hold_ch = out_chan; end
    end
    chk("t3_hold_cnt", out_count, hold_cnt);
    chk("t3_hold_ch",  out_chan, hold_ch);
    chk("t3_ovr", overrun, 1);
    pulse_stop();
    out_ready = 1'b1; ticks(10);
    chk("t3_words", lch.size(), 8);

    // Test 4: stop mid-window, no output
    lch.delete(); lcnt.delete();
    pulse_start(10);
    spike_in = 8'h08; ticks(4);
    pulse_stop();
    chk("t4_busy", busy, 0);
    spike_in = 8'h00; ticks(15);
    chk("t4_words", lch.size(), 0);

    // Test 5: start and stop together stay idle
    start = 1'b1; stop = 1'b1; win_len = 8'd2; tick();
    start = 1'b0; stop = 1'b0;
    chk("t5_busy", busy, 0);
    ticks(5);
    chk("t5_busy2", busy, 0);

    // Test 6: reset mid-drain, then restart
    pulse_start(3);
    spike_in = 8'h5A;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (out_valid && out_chan == 3'd4) found = 1;
    end
    chk("t6_reach", found, 1);
    rst = 1'b1; tick();
    chk("t6_valid", out_valid, 0);
    chk("t6_chan",  out_chan, 0);
    chk("t6_count", out_count, 0);
    chk("t6_ovr",   overrun, 0);
    chk("t6_busy",  busy, 0);
    rst = 1'b0; spike_in = 8'h01; tick();
    lch.delete(); lcnt.delete();
    pulse_start(2);
    ticks(12);
    pulse_stop(); ticks(4);
    chk("t6_words", (lch.size() >= 8) ? 1 : 0, 1);
    if (lch.size() > 0) begin
      chk("t6_c0ch", lch[0], 0);
      chk("t6_c0",   lcnt[0], 2);
    end

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 500) == 0;
      start     = ($urandom % 25) == 0;
      stop      = ($urandom % 80) == 0;
      win_len   = (($urandom % 50) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      spike_in  = NCH'($urandom);
      out_ready = (($urandom % 64) < 8) ? 1'b0 : (($urandom % 4) != 0);
      tick();
    end
    rst = 0; start = 0; stop = 0;
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
